alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the 3-bit-command combinational ALU.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Valid/ready operand and result bundle between operand-fetch, the sequential ALU
// and writeback.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       command;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, command, operandA, operandB, out_ready,
    input  in_ready, out_valid, result, carryout, zero, overflow
  );

  modport slave (
    input  in_valid, command, operandA, operandB, out_ready,
    output in_ready, out_valid, result, carryout, zero, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ADD/SUB/XOR/SLT/CNE, one-bit-per-cycle
// SLL/SRL and shift-add MUL, with result and flags registered behind valid/ready.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] MUL_TERM = CW'(WIDTH - 1);

  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_SUB = 3'd1;
  localparam logic [2:0] CMD_XOR = 3'd2;
  localparam logic [2:0] CMD_SLT = 3'd3;
  localparam logic [2:0] CMD_CNE = 3'd4;
  localparam logic [2:0] CMD_SLL = 3'd5;
  localparam logic [2:0] CMD_MUL = 3'd6;
  localparam logic [2:0] CMD_SRL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
  } alu_out_t;

  state_t             state_r, state_nx_s;
  logic               in_ready_s, out_valid_s;
  logic               accept_s, needs_exec_s, term_s;
  logic [SW-1:0]      shamt_in_s;
  alu_out_t           single_s;
  logic [WIDTH-1:0]   shift_nx_s;
  logic               shift_out_s;
  logic [2*WIDTH-1:0] pp_sum_s;

  logic [2:0]         cmd_r;
  logic [SW-1:0]      shamt_r;
  logic [CW-1:0]      count_r;
  logic [WIDTH-1:0]   sh_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   result_r;
  logic               carry_r, zero_r, ovf_r;

  // Commands finishing in the accept cycle; shifts only arrive here with shamt=0.
  function automatic alu_out_t single_op(input logic [2:0] cmd,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic [WIDTH:0] add_v, sub_v;
    logic           add_ovf, sub_ovf;
    alu_out_t       o;
    add_v   = {1'b0, a} + {1'b0, b};
    sub_v   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_v[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_v[WIDTH-1] != a[WIDTH-1]);
    o.res   = {WIDTH{1'b0}};
    o.carry = 1'b0;
    o.ovf   = 1'b0;
    case (cmd)
      CMD_ADD: begin
        o.res   = add_v[WIDTH-1:0];
        o.carry = add_v[WIDTH];
        o.ovf   = add_ovf;
      end
      CMD_SUB: begin
        o.res   = sub_v[WIDTH-1:0];
        o.carry = sub_v[WIDTH];
        o.ovf   = sub_ovf;
      end
      CMD_XOR: o.res = a ^ b;
      CMD_SLT: o.res = {{(WIDTH-1){1'b0}}, sub_v[WIDTH-1] ^ sub_ovf};
      CMD_CNE: o.res = {{(WIDTH-1){1'b0}}, (a != b)};
      CMD_SLL: o.res = a;
      CMD_SRL: o.res = a;
      CMD_MUL: o.ovf = 1'b1;
      default: o.res = {WIDTH{1'b0}};
    endcase
    return o;
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = needs_exec_s ? ST_EXEC : ST_DONE;
        else          state_nx_s = ST_IDLE;
      end
      ST_EXEC: begin
        if (term_s) state_nx_s = ST_DONE;
        else        state_nx_s = ST_EXEC;
      end
      ST_DONE: begin
        if (accept_s)           state_nx_s = needs_exec_s ? ST_EXEC : ST_DONE;
        else if (bus.out_ready) state_nx_s = ST_IDLE;
        else                    state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM handshake outputs
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_EXEC: in_ready_s = 1'b0;
      ST_DONE: begin
        in_ready_s  = bus.out_ready;
        out_valid_s = 1'b1;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  // Accept decode and per-cycle shift / partial-product step
  always_comb begin
    accept_s   = bus.in_valid & in_ready_s;
    shamt_in_s = bus.operandB[SW-1:0];
    single_s   = single_op(bus.command, bus.operandA, bus.operandB);
    if ((bus.command == CMD_MUL) && MUL_EN) begin
      needs_exec_s = 1'b1;
    end else if (((bus.command == CMD_SLL) || (bus.command == CMD_SRL)) &&
                 (shamt_in_s != {SW{1'b0}})) begin
      needs_exec_s = 1'b1;
    end else begin
      needs_exec_s = 1'b0;
    end
    if (cmd_r == CMD_SLL) begin
      shift_nx_s  = {sh_r[WIDTH-2:0], 1'b0};
      shift_out_s = sh_r[WIDTH-1];
    end else begin
      shift_nx_s  = {1'b0, sh_r[WIDTH-1:1]};
      shift_out_s = sh_r[0];
    end
    if (mplier_r[0]) pp_sum_s = acc_r + mcand_r;
    else             pp_sum_s = acc_r;
    // The step taken on the terminal edge is the last one, so result comes from it.
    if (cmd_r == CMD_MUL) term_s = (count_r == MUL_TERM);
    else                  term_s = (count_r == ({1'b0, shamt_r} - CNT_ONE));
  end

  // Operand latch, iteration state and registered result/flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_r    <= 3'd0;
      shamt_r  <= {SW{1'b0}};
      count_r  <= {CW{1'b0}};
      sh_r     <= {WIDTH{1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      result_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept_s) begin
      cmd_r    <= bus.command;
      shamt_r  <= shamt_in_s;
      count_r  <= {CW{1'b0}};
      sh_r     <= bus.operandA;
      mcand_r  <= {{WIDTH{1'b0}}, bus.operandA};
      mplier_r <= bus.operandB;
      acc_r    <= {(2*WIDTH){1'b0}};
      if (!needs_exec_s) begin
        result_r <= single_s.res;
        carry_r  <= single_s.carry;
        ovf_r    <= single_s.ovf;
        zero_r   <= (single_s.res == {WIDTH{1'b0}});
      end
    end else if (state_r == ST_EXEC) begin
      count_r  <= count_r + CNT_ONE;
      sh_r     <= shift_nx_s;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      acc_r    <= pp_sum_s;
      if (term_s) begin
        if (cmd_r == CMD_MUL) begin
          result_r <= pp_sum_s[WIDTH-1:0];
          carry_r  <= 1'b0;
          ovf_r    <= (pp_sum_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
          zero_r   <= (pp_sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
        end else begin
          result_r <= shift_nx_s;
          carry_r  <= shift_out_s;
          ovf_r    <= 1'b0;
          zero_r   <= (shift_nx_s == {WIDTH{1'b0}});
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.result    = result_r;
  assign bus.carryout  = carry_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand-written handshake/reset sequences
// and random operations scored against an arithmetic reference model.
module tb_alu_seq;

  logic clk;
  logic reset;

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  alu_seq #(.WIDTH(8),  .MUL_EN(1'b0)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        v;
    int          lat;
  } obs_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        v;
    int          lat;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input obs_t got, input obs_t exp);
    check({tag, ".res"}, {32'h0, got.res}, {32'h0, exp.res});
    check({tag, ".carry"}, {63'h0, got.c}, {63'h0, exp.c});
    check({tag, ".zero"}, {63'h0, got.z}, {63'h0, exp.z});
    check({tag, ".ovf"}, {63'h0, got.v}, {63'h0, exp.v});
    check({tag, ".lat"}, 64'(got.lat), 64'(exp.lat));
  endtask

  // Reference behaviour from the arithmetic definitions of each command.
  function automatic obs_t model(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    obs_t        e;
    logic [63:0] wide;
    longint      sv;
    int          s;
    s     = int'(b[4:0]);
    e.res = 32'h0;
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.lat = 1;
    case (cmd)
      3'd0: begin
        wide  = {32'h0, a} + {32'h0, b};
        e.res = wide[31:0];
        e.c   = wide[32];
        sv    = longint'($signed(a)) + longint'($signed(b));
        e.v   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      3'd1: begin
        e.res = a - b;
        e.c   = (a >= b);
        sv    = longint'($signed(a)) - longint'($signed(b));
        e.v   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      3'd2: e.res = a ^ b;
      3'd3: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: e.res = (a != b) ? 32'd1 : 32'd0;
      3'd5: begin
        wide  = {32'h0, a} << s;
        e.res = wide[31:0];
        e.c   = (s != 0) && wide[32];
        e.lat = s + 1;
      end
      3'd6: begin
        wide  = {32'h0, a} * {32'h0, b};
        e.res = wide[31:0];
        e.v   = (wide[63:32] != 32'h0);
        e.lat = 33;
      end
      default: begin
        e.res = a >> s;
        if (s != 0) e.c = a[s-1];
        else        e.c = 1'b0;
        e.lat = s + 1;
      end
    endcase
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  task automatic do_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       output obs_t got);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.command   = cmd;
    bus.operandA  = a;
    bus.operandB  = b;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    got.lat = 1;
    while ((bus.out_valid !== 1'b1) && (got.lat < 100)) begin
      @(posedge clk);
      #1;
      got.lat++;
    end
    got.res = bus.result;
    got.c   = bus.carryout;
    got.z   = bus.zero;
    got.v   = bus.overflow;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[19];
    obs_t got;
    obs_t exp;

    vecs[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1};
    vecs[1]  = '{3'd1, 32'h00000014, 32'h00000014, 32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{3'd4, 32'h00000014, 32'h00000014, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{3'd4, 32'h00000014, 32'h00000015, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd3, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{3'd2, 32'h000000F0, 32'h000000FF, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    vecs[8]  = '{3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1};
    vecs[10] = '{3'd5, 32'h80000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 1'b0, 5};
    vecs[11] = '{3'd7, 32'h0000000F, 32'h00000001, 32'h00000007, 1'b1, 1'b0, 1'b0, 2};
    vecs[12] = '{3'd5, 32'h00001234, 32'h00000020, 32'h00001234, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{3'd7, 32'hC0000000, 32'h0000001F, 32'h00000001, 1'b1, 1'b0, 1'b0, 32};
    vecs[14] = '{3'd5, 32'h00000001, 32'h00000025, 32'h00000020, 1'b0, 1'b0, 1'b0, 6};
    vecs[15] = '{3'd6, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 1'b1, 1'b1, 33};
    vecs[16] = '{3'd6, 32'h00000006, 32'h00000007, 32'h0000002A, 1'b0, 1'b0, 1'b0, 33};
    vecs[17] = '{3'd3, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[18] = '{3'd5, 32'h00000003, 32'h0000001F, 32'h80000000, 1'b1, 1'b0, 1'b0, 32};

    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.command    = 3'd0;
    bus.operandA   = 32'h0;
    bus.operandB   = 32'h0;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.command   = 3'd0;
    bus8.operandA  = 8'h0;
    bus8.operandB  = 8'h0;
    bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst.in_ready", {63'h0, bus.in_ready}, 64'h1);
    check("rst.out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst.result", {32'h0, bus.result}, 64'h0);
    check("rst.carry", {63'h0, bus.carryout}, 64'h0);
    check("rst.zero", {63'h0, bus.zero}, 64'h0);
    check("rst.ovf", {63'h0, bus.overflow}, 64'h0);

    for (int i = 0; i < 19; i++) begin
      do_op(vecs[i].cmd, vecs[i].a, vecs[i].b, got);
      exp = '{vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].lat};
      compare($sformatf("vec%0d", i), got, exp);
    end

    // Backpressure: ADD held for five cycles while a blocked XOR waits on in_valid.
    go_idle();
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.command   = 3'd0;
    bus.operandA  = 32'd3;
    bus.operandB  = 32'd4;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.command  = 3'd2;
    bus.operandA = 32'hF0;
    bus.operandB = 32'hFF;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d.out_valid", i), {63'h0, bus.out_valid}, 64'h1);
      check($sformatf("bp%0d.result", i), {32'h0, bus.result}, 64'd7);
      check($sformatf("bp%0d.in_ready", i), {63'h0, bus.in_ready}, 64'h0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("bp.in_ready_release", {63'h0, bus.in_ready}, 64'h1);
    @(posedge clk);
    #1;
    check("bp.xor_valid", {63'h0, bus.out_valid}, 64'h1);
    check("bp.xor_result", {32'h0, bus.result}, 64'h0F);

    // Back-to-back single-cycle ops: one result per edge.
    for (int i = 0; i < 5; i++) begin
      logic [31:0] ta, tb;
      ta = $urandom;
      tb = $urandom;
      exp = model(3'(i), ta, tb);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.command  = 3'(i);
      bus.operandA = ta;
      bus.operandB = tb;
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d.out_valid", i), {63'h0, bus.out_valid}, 64'h1);
      check($sformatf("b2b%0d.result", i), {32'h0, bus.result}, {32'h0, exp.res});
      check($sformatf("b2b%0d.carry", i), {63'h0, bus.carryout}, {63'h0, exp.c});
      check($sformatf("b2b%0d.ovf", i), {63'h0, bus.overflow}, {63'h0, exp.v});
    end
    bus.in_valid = 1'b0;

    // Narrow instance without multiplier: command 6 is a single-cycle error.
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.command  = 3'd6;
    bus8.operandA = 8'h12;
    bus8.operandB = 8'h34;
    @(posedge clk);
    #1;
    check("w8mul.out_valid", {63'h0, bus8.out_valid}, 64'h1);
    check("w8mul.result", {56'h0, bus8.result}, 64'h0);
    check("w8mul.ovf", {63'h0, bus8.overflow}, 64'h1);
    check("w8mul.zero", {63'h0, bus8.zero}, 64'h1);
    check("w8mul.carry", {63'h0, bus8.carryout}, 64'h0);
    @(negedge clk);
    bus8.command  = 3'd0;
    bus8.operandA = 8'h7F;
    bus8.operandB = 8'h01;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    check("w8add.result", {56'h0, bus8.result}, 64'h80);
    check("w8add.ovf", {63'h0, bus8.overflow}, 64'h1);
    check("w8add.carry", {63'h0, bus8.carryout}, 64'h0);

    // Asynchronous reset in the middle of a multiply.
    do_op(3'd0, 32'hFFFFFFFF, 32'h2, got);
    compare("pre_rst", got, model(3'd0, 32'hFFFFFFFF, 32'h2));
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.command  = 3'd6;
    bus.operandA = 32'd5;
    bus.operandB = 32'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_mul.out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("mid_mul.result_held", {32'h0, bus.result}, 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst.out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("arst.result", {32'h0, bus.result}, 64'h0);
    check("arst.carry", {63'h0, bus.carryout}, 64'h0);
    check("arst.zero", {63'h0, bus.zero}, 64'h0);
    check("arst.ovf", {63'h0, bus.overflow}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst.in_ready", {63'h0, bus.in_ready}, 64'h1);
    do_op(3'd0, 32'd1, 32'd1, got);
    exp = '{32'd2, 1'b0, 1'b0, 1'b0, 1};
    compare("post_rst", got, exp);

    // Random operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  rc;
      logic [31:0] ra, rb;
      rc = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) rb = ra;
      do_op(rc, ra, rb, got);
      compare($sformatf("rnd%0d_cmd%0d", i, rc), got, model(rc, ra, rb));
    end

    go_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
